// File: rtl/touch_pad_decoder.sv
// Touch-pad input decoder: per-pad two-flop synchroniser, debounce FSM and
// registered press / release / long-press strobes for active-low pulled-up pads.
module touch_pad_decoder #(
   parameter int N_PADS        = 2,
   parameter int DEBOUNCE_LOG2 = 16,
   parameter int LONG_LOG2     = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_PADS-1:0] pad_n,
   output logic [N_PADS-1:0] pressed,
   output logic [N_PADS-1:0] press_pulse,
   output logic [N_PADS-1:0] release_pulse,
   output logic [N_PADS-1:0] long_pulse
);

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESSED,
      ST_LONG
   } state_e;

   logic [N_PADS-1:0]        s1_q, s2_q;
   state_e                   state_q [N_PADS];
   state_e                   state_d [N_PADS];
   logic [DEBOUNCE_LOG2-1:0] dcnt_q  [N_PADS];
   logic [DEBOUNCE_LOG2-1:0] dcnt_d  [N_PADS];
   logic [LONG_LOG2-1:0]     hcnt_q  [N_PADS];
   logic [LONG_LOG2-1:0]     hcnt_d  [N_PADS];
   logic [N_PADS-1:0]        press_q, press_d;
   logic [N_PADS-1:0]        release_q, release_d;
   logic [N_PADS-1:0]        long_q, long_d;
   logic [N_PADS-1:0]        active;

   assign active        = ~s2_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;

   always_comb begin
      for (int unsigned i = 0; i < N_PADS; i++) begin
         state_d[i]   = state_q[i];
         dcnt_d[i]    = dcnt_q[i];
         hcnt_d[i]    = hcnt_q[i];
         press_d[i]   = 1'b0;
         release_d[i] = 1'b0;
         long_d[i]    = 1'b0;
         pressed[i]   = (state_q[i] != ST_RELEASED);

         case (state_q[i])
            ST_RELEASED: begin
               if (!active[i]) begin
                  dcnt_d[i] = '0;
               end else if (dcnt_q[i] == '1) begin
                  state_d[i] = ST_PRESSED;
                  dcnt_d[i]  = '0;
                  hcnt_d[i]  = '0;
                  press_d[i] = 1'b1;
               end else begin
                  dcnt_d[i] = dcnt_q[i] + 1'b1;
               end
            end
            ST_PRESSED, ST_LONG: begin
               if (active[i]) begin
                  dcnt_d[i] = '0;
               end else if (dcnt_q[i] != '1) begin
                  dcnt_d[i] = dcnt_q[i] + 1'b1;
               end
               // A release confirmed on the same edge as the long threshold takes priority.
               if (!active[i] && (dcnt_q[i] == '1)) begin
                  state_d[i]   = ST_RELEASED;
                  dcnt_d[i]    = '0;
                  release_d[i] = 1'b1;
               end else if (state_q[i] == ST_PRESSED) begin
                  if (hcnt_q[i] == '1) begin
                     state_d[i] = ST_LONG;
                     long_d[i]  = 1'b1;
                  end else begin
                     hcnt_d[i] = hcnt_q[i] + 1'b1;
                  end
               end
            end
            default: begin
               state_d[i] = ST_RELEASED;
               dcnt_d[i]  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '1;
         s2_q      <= '1;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int unsigned i = 0; i < N_PADS; i++) begin
            state_q[i] <= ST_RELEASED;
            dcnt_q[i]  <= '0;
            hcnt_q[i]  <= '0;
         end
      end else begin
         s1_q      <= pad_n;
         s2_q      <= s1_q;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         for (int unsigned i = 0; i < N_PADS; i++) begin
            state_q[i] <= state_d[i];
            dcnt_q[i]  <= dcnt_d[i];
            hcnt_q[i]  <= hcnt_d[i];
         end
      end
   end

endmodule
